// File: rtl/ps_pkg.sv
// +--------------------------------------------------------------------------+
// | ps_pkg : shared constants, clog2 helper and phase enum for the serialiser |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package ps_pkg;

  localparam logic [7:0] K28_5     = 8'hBC;
  localparam logic [9:0] K28_5_10B = 10'h17C;

  typedef enum logic {
    PH_SYNC = 1'b0,
    PH_RUN  = 1'b1
  } phase_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps_hold_reg.sv
// +--------------------------------------------------------------------------+
// | ps_hold_reg : one-entry skid/hold register with valid/ready handshake     |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module ps_hold_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] data_in,
  input  logic         valid_in,
  input  logic         enable,
  input  logic         take,
  output logic         ready,
  output logic [W-1:0] hold,
  output logic         hold_full
);

  logic accept;

  // A word can be taken when empty, or when the held word leaves on this edge.
  assign ready  = enable && (!hold_full || take);
  assign accept = valid_in && ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else if (accept) begin
      hold      <= data_in;
      hold_full <= 1'b1;
    end else if (take) begin
      hold_full <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/paralelo_serial_param.sv
// +--------------------------------------------------------------------------+
// | paralelo_serial_param : DATA_W-bit words out LANE_W bits/cycle, MSB first |
// | optional macro PS_WORD_COUNT_EN adds the word_count port.   rev 1.0       |
// +--------------------------------------------------------------------------+
`default_nettype none

module paralelo_serial_param
  import ps_pkg::*;
#(
  parameter int                DATA_W      = 8,
  parameter int                LANE_W      = 2,
  parameter logic [DATA_W-1:0] IDLE_CHAR   = DATA_W'(K28_5),
  parameter int                SYNC_COMMAS = 4
) (
  input  logic              clk16f,
  input  logic              reset_L,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic [LANE_W-1:0] serial,
  output logic              data_active
`ifdef PS_WORD_COUNT_EN
  ,
  output logic [15:0]       word_count
`endif
);

  localparam int BEATS    = DATA_W / LANE_W;
  localparam int BEAT_W   = (clog2(BEATS) > 0) ? clog2(BEATS) : 1;
  localparam int SYNC_W   = (clog2(SYNC_COMMAS + 1) > 0) ? clog2(SYNC_COMMAS + 1) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  logic [DATA_W-1:0] sr;
  logic [BEAT_W-1:0] beat;
  logic [SYNC_W-1:0] sync_cnt;
  phase_t            phase;

  logic              load;
  logic              sync_phase;
  logic              take;
  logic              hold_full;
  logic [DATA_W-1:0] hold;

  assign load       = (beat == LAST_BEAT);
  assign sync_phase = (phase == PH_SYNC);
  assign take       = load && !sync_phase && hold_full;
  assign serial     = sr[DATA_W-1 -: LANE_W];

  ps_hold_reg #(
    .W (DATA_W)
  ) u_hold (
    .clk       (clk16f),
    .rst_n     (reset_L),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .enable    (!sync_phase),
    .take      (take),
    .ready     (ready_out),
    .hold      (hold),
    .hold_full (hold_full)
  );

  // Phase stays SYNC until the load that issues the last preamble comma;
  // with no preamble it leaves SYNC on the very first load after reset.
  always_ff @(posedge clk16f or negedge reset_L) begin
    if (!reset_L) begin
      sr          <= '0;
      beat        <= LAST_BEAT;
      sync_cnt    <= '0;
      phase       <= PH_SYNC;
      data_active <= 1'b0;
    end else if (load) begin
      beat <= '0;
      if (sync_phase) begin
        sr          <= IDLE_CHAR;
        data_active <= 1'b0;
        if (int'(sync_cnt) < SYNC_COMMAS) sync_cnt <= sync_cnt + 1'b1;
        if (int'(sync_cnt) + 1 >= SYNC_COMMAS) phase <= PH_RUN;
      end else if (hold_full) begin
        sr          <= hold;
        data_active <= 1'b1;
      end else begin
        sr          <= IDLE_CHAR;
        data_active <= 1'b0;
      end
    end else begin
      beat <= beat + 1'b1;
      sr   <= sr << LANE_W;
    end
  end

`ifdef PS_WORD_COUNT_EN
  always_ff @(posedge clk16f or negedge reset_L) begin
    if (!reset_L) word_count <= '0;
    else if (take) word_count <= word_count + 16'd1;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_paralelo_serial_param.sv
// +--------------------------------------------------------------------------+
// | tb_paralelo_serial_param : default 8b/2-lane and 10b/1-lane instances     |
// | against a word-level reference model.                         rev 1.0    |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_paralelo_serial_param;

  localparam int AW = 8, AL = 2, BW = 10, BL = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [AW-1:0] a_din;
  logic          a_valid, a_ready, a_act;
  logic [AL-1:0] a_ser;
  logic [BW-1:0] b_din;
  logic          b_valid, b_ready, b_act;
  logic [BL-1:0] b_ser;
`ifdef PS_WORD_COUNT_EN
  logic [15:0]   a_wc, b_wc;
`endif

  paralelo_serial_param dut_a (
    .clk16f      (clk),
    .reset_L     (rst_n),
    .data_in     (a_din),
    .valid_in    (a_valid),
    .ready_out   (a_ready),
    .serial      (a_ser),
    .data_active (a_act)
`ifdef PS_WORD_COUNT_EN
    , .word_count (a_wc)
`endif
  );

  paralelo_serial_param #(
    .DATA_W      (BW),
    .LANE_W      (BL),
    .IDLE_CHAR   (10'h17C),
    .SYNC_COMMAS (0)
  ) dut_b (
    .clk16f      (clk),
    .reset_L     (rst_n),
    .data_in     (b_din),
    .valid_in    (b_valid),
    .ready_out   (b_ready),
    .serial      (b_ser),
    .data_active (b_act)
`ifdef PS_WORD_COUNT_EN
    , .word_count (b_wc)
`endif
  );

  // Per-instance configuration
  int          p_dw[2]   = '{8, 10};
  int          p_lw[2]   = '{2, 1};
  int          p_sync[2] = '{4, 0};
  logic [15:0] p_idle[2] = '{16'h00BC, 16'h017C};

  // Reference model: edges since reset, commas already issued, pending word,
  // and the word currently on the wire.
  int          m_edges[2];
  int          m_sync_sent[2];
  bit          m_pend[2];
  logic [15:0] m_pval[2];
  logic [15:0] m_cur[2];
  bit          m_act[2];
  int          m_wc[2];

  logic [15:0] qa[$];
  logic [15:0] qb[$];
  bit          stream;
  int          n_checks = 0;
  int          n_pass   = 0;

  function automatic int beats(input int d);
    return p_dw[d] / p_lw[d];
  endfunction

  function automatic logic [15:0] wmask(input int d);
    return (16'd1 << p_dw[d]) - 16'd1;
  endfunction

  function automatic void model_reset(input int d);
    m_edges[d] = 0; m_sync_sent[d] = 0; m_pend[d] = 0; m_pval[d] = '0;
    m_cur[d] = '0; m_act[d] = 0; m_wc[d] = 0;
  endfunction

  function automatic bit exp_ready(input int d);
    bit boundary_next;
    boundary_next = (m_edges[d] % beats(d)) == 0;
    return (m_edges[d] > 0) && (m_sync_sent[d] >= p_sync[d]) && (!m_pend[d] || boundary_next);
  endfunction

  function automatic logic [15:0] exp_serial(input int d);
    int k, sh;
    if (m_edges[d] == 0) return '0;
    k  = (m_edges[d] - 1) % beats(d);
    sh = p_dw[d] - p_lw[d] * (k + 1);
    return (m_cur[d] >> sh) & ((16'd1 << p_lw[d]) - 16'd1);
  endfunction

  function automatic bit model_edge(input int d, input bit v, input logic [15:0] data);
    bit xfer;
    xfer = v && exp_ready(d);
    if ((m_edges[d] % beats(d)) == 0) begin
      if (m_sync_sent[d] < p_sync[d]) begin
        m_cur[d] = p_idle[d]; m_act[d] = 0; m_sync_sent[d]++;
      end else if (m_pend[d]) begin
        m_cur[d] = m_pval[d]; m_act[d] = 1; m_pend[d] = 0; m_wc[d]++;
      end else begin
        m_cur[d] = p_idle[d]; m_act[d] = 0;
      end
    end
    if (xfer) begin
      m_pend[d] = 1; m_pval[d] = data;
    end
    m_edges[d]++;
    return xfer;
  endfunction

  task automatic chk(input string tag, input int d, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s dut%0d: got %0h expected %0h", tag, d, got, exp);
  endtask

  task automatic check_dut(input int d);
    if (d == 0) begin
      chk("serial", 0, 16'(a_ser), exp_serial(0));
      chk("ready", 0, 16'(a_ready), 16'(exp_ready(0)));
      chk("data_active", 0, 16'(a_act), 16'(m_act[0]));
`ifdef PS_WORD_COUNT_EN
      chk("word_count", 0, a_wc, 16'(m_wc[0]));
`endif
    end else begin
      chk("serial", 1, 16'(b_ser), exp_serial(1));
      chk("ready", 1, 16'(b_ready), 16'(exp_ready(1)));
      chk("data_active", 1, 16'(b_act), 16'(m_act[1]));
`ifdef PS_WORD_COUNT_EN
      chk("word_count", 1, b_wc, 16'(m_wc[1]));
`endif
    end
  endtask

  // Called at a falling edge: check state, drive inputs, predict next rising edge.
  task automatic cycle();
    bit          va, vb;
    logic [15:0] da, db;
    check_dut(0);
    check_dut(1);
    va = 0; da = 16'($urandom) & wmask(0);
    if (qa.size() > 0 && (stream || $urandom_range(0, 2) != 0)) begin
      va = 1; da = qa[0];
    end
    vb = 0; db = 16'($urandom) & wmask(1);
    if (qb.size() > 0 && (stream || $urandom_range(0, 2) != 0)) begin
      vb = 1; db = qb[0];
    end
    a_valid = va; a_din = da[AW-1:0];
    b_valid = vb; b_din = db[BW-1:0];
    if (model_edge(0, va, da)) void'(qa.pop_front());
    if (model_edge(1, vb, db)) void'(qb.pop_front());
    @(negedge clk);
  endtask

  initial begin
    int guard;
    rst_n = 1'b0; a_valid = 1'b0; a_din = '0; b_valid = 1'b0; b_din = '0;
    stream = 1'b1;
    model_reset(0); model_reset(1);
    repeat (3) @(negedge clk);
    check_dut(0); check_dut(1);
    rst_n = 1'b1;

    // Preamble with 8'h33 offered during SYNC; B streams its first three words.
    qa.push_back(16'h33);
    qb.push_back(16'h2A5); qb.push_back(16'h0F0); qb.push_back(16'h3C3);
    repeat (24) cycle();

    qa.push_back(16'h5A);
    repeat (12) cycle();

    qa.push_back(16'h00); qa.push_back(16'hFF); qa.push_back(16'hA5);
    repeat (18) cycle();

    // Randomised traffic with random valid gaps
    stream = 1'b0;
    for (int i = 0; i < 40; i++) begin
      qa.push_back(16'($urandom_range(0, 255)));
      qb.push_back(16'($urandom_range(0, 1023)));
    end
    repeat (260) cycle();

    // Asynchronous reset in the middle of a data word with another word held
    stream = 1'b1;
    qa.push_back(16'hC3); qa.push_back(16'h96); qa.push_back(16'h81);
    guard = 0;
    while (!(m_act[0] && m_pend[0] && (m_edges[0] % 4) == 2) && guard < 60) begin
      cycle();
      guard++;
    end
    chk("midword_reach", 0, 16'(guard < 60), 16'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset(0); model_reset(1);
    qa.delete(); qb.delete();
    check_dut(0); check_dut(1);
    @(negedge clk);
    check_dut(0); check_dut(1);
    rst_n = 1'b1;
    qa.push_back(16'h77);
    qb.push_back(16'h155);
    repeat (28) cycle();
    check_dut(0); check_dut(1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
